player_bullet: RTL and testbench
================================

Name: player_bullet

Overview:
Single player-shot engine for Space Invaders. It sits directly upstream of the enemy grid.
- Drives the bullet coordinates bx/by that the grid hit-tests against.
- Consumes the grid's b_hit to retire the shot.
- Produces the bullet's video pixel for the top-level RGB mux.
- At most one bullet is in flight. Motion advances once per frame tick.

Parameters:
SPAWN_Y, 170, y coordinate the bullet spawns at (just above the player sprite).
X_OFFSET, 3, added to player x to centre the bullet on the cannon.
TOP_Y, 2, bullet retires (miss) when a move would take by below this row.
SPEED, 3, pixels moved upward per frame tick.
BW, 1, bullet width in pixels.
BH, 4, bullet height in pixels.
COOLDOWN, 4, frame ticks after retirement before a new shot is accepted.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous reset, active-high.
tick  in  1  one-cycle pulse per video frame (end of active scan).
fire  in  1  fire button level, already synchronised.
px  in  10  player cannon left x.
gg  in  1  game over; blocks new shots.
b_hit  in  1  enemy grid reports the bullet overlaps a live enemy.
vga_x  in  10  current scan x.
vga_y  in  9  current scan y.
bx  out  10  bullet x; 0 when not flying.
by  out  9  bullet y; 0 when not flying.
active  out  1  high while in FLY.
pixel  out  1  scan position lies inside the bullet rectangle.
shots  out  8  shots fired since reset, saturating at 255.

Behaviour:
Reset (async, active-high) values:
- state=IDLE; bx=0, by=0 (parked off-grid); active=0; pixel=0; shots=0; cooldown counter=0; fire edge register=0.

States and transitions:
- IDLE: accept a shot on a rising edge of fire (fire=1 this cycle, 0 last cycle) when gg=0.
  - Next cycle: state=FLY, bx=px+X_OFFSET (10-bit, wraps), by=SPAWN_Y, shots+=1 (saturating at 255).
- FLY:
  - b_hit=1 -> COOL on the next clock. b_hit has priority over a tick in the same cycle: no move occurs that cycle.
  - Otherwise on tick: if by < TOP_Y+SPEED -> COOL (miss); else by <= by-SPEED.
  - by is never allowed to underflow.
  - gg=1 -> COOL immediately; a bullet in flight is cancelled.
- COOL:
  - On entry: bx=0, by=0, cooldown counter loaded with COOLDOWN.
  - Each tick decrements the counter.
  - When the counter reaches 0 -> IDLE.
  - COOLDOWN=0 returns to IDLE on the next clock.
- fire edges seen outside IDLE are discarded, not queued.

Outputs:
- active = (state==FLY), registered.
- pixel is combinational: active && bx <= vga_x < bx+BW && by <= vga_y < by+BH. Comparisons are done at 11 bits so no wrap occurs.
- b_hit is ignored outside FLY.

Latency: fire edge to active=1 is 1 clock. b_hit to bx/by=0 is 1 clock.

Reset mid-flight: everything returns to reset values asynchronously, and shots clears.

Optional Feature:
AUTO_FIRE_EN
- Defined: in IDLE the fire level (not its edge) launches a shot, so a held button re-fires as soon as cooldown expires. shots still saturates.
- Undefined: rising-edge only, as specified above. The edge register is still present but only used when undefined.

Test Plan:
- Reset, px=100, fire 0->1 -> next clock active=1, bx=103, by=170, shots=1.
- FLY from by=170, 10 ticks, no hit -> by=140; holding fire high throughout -> shots stays 1.
- From by=5, tick -> 5<2+3 false, by=2; next tick -> COOL, bx=0, by=0, active=0; after 4 ticks IDLE and a new fire edge is accepted.
- b_hit and tick in the same cycle at by=50 -> next clock COOL, bx=by=0, no move; fire edge during COOL ignored.
- bx=103, by=140: vga=(103,140) and (103,143) -> pixel=1; vga=(104,140) and (103,144) -> pixel=0.
- gg=1 mid-flight -> next clock COOL; fire edge with gg=1 in IDLE -> no launch.
- With AUTO_FIRE_EN: fire held high -> relaunch on the clock after cooldown reaches 0.
- 300 shots -> shots=255.

Source files
------------

// File: rtl/player_bullet_if.sv
// Signal bundle between the player-shot engine and its surroundings
// (frame tick, controls, enemy-grid hit test and video scan position).
interface player_bullet_if;
    logic       tick;
    logic       fire;
    logic [9:0] px;
    logic       gg;
    logic       b_hit;
    logic [9:0] vga_x;
    logic [8:0] vga_y;
    logic [9:0] bx;
    logic [8:0] by;
    logic       active;
    logic       pixel;
    logic [7:0] shots;

    modport slave (
        input  tick, fire, px, gg, b_hit, vga_x, vga_y,
        output bx, by, active, pixel, shots
    );

    modport master (
        output tick, fire, px, gg, b_hit, vga_x, vga_y,
        input  bx, by, active, pixel, shots
    );
endinterface

// File: rtl/player_bullet.sv
// Single player-shot engine: spawns, moves and retires one bullet and draws it.
// Optional macro AUTO_FIRE_EN: fire level (instead of its rising edge) launches a shot.
module player_bullet #(
    parameter int SPAWN_Y  = 170,
    parameter int X_OFFSET = 3,
    parameter int TOP_Y    = 2,
    parameter int SPEED    = 3,
    parameter int BW       = 1,
    parameter int BH       = 4,
    parameter int COOLDOWN = 4
) (
    input logic            clk,
    input logic            reset,
    player_bullet_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FLY  = 2'd1;
    localparam logic [1:0] COOL = 2'd2;

    // A move from below this row would pass TOP_Y, so the shot is a miss instead.
    localparam logic [8:0] MISS_Y = 9'(TOP_Y + SPEED);

    logic [1:0]  state_r, state_s;
    logic [9:0]  bx_r, bx_s;
    logic [8:0]  by_r, by_s;
    logic [7:0]  shots_r, shots_s;
    logic [7:0]  cool_r, cool_s;
    logic        active_r;
    logic        fire_q_r;
    logic        fire_ok_s;
    logic [10:0] scan_x_s, scan_y_s, bx_w_s, by_w_s;

`ifdef AUTO_FIRE_EN
    assign fire_ok_s = bus.fire;
`else
    assign fire_ok_s = bus.fire & ~fire_q_r;
`endif

    // Next-state and next-coordinate logic for the shot lifecycle.
    always_comb begin
        state_s = state_r;
        bx_s    = bx_r;
        by_s    = by_r;
        shots_s = shots_r;
        cool_s  = cool_r;
        case (state_r)
            IDLE: begin
                if (fire_ok_s && !bus.gg) begin
                    state_s = FLY;
                    bx_s    = bus.px + 10'(X_OFFSET);
                    by_s    = 9'(SPAWN_Y);
                    if (shots_r != 8'd255) begin
                        shots_s = shots_r + 8'd1;
                    end else begin
                        shots_s = shots_r;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FLY: begin
                // Game over and a hit both retire the shot; neither lets a tick move it.
                if (bus.gg || bus.b_hit || (bus.tick && (by_r < MISS_Y))) begin
                    state_s = COOL;
                    bx_s    = 10'd0;
                    by_s    = 9'd0;
                    cool_s  = 8'(COOLDOWN);
                end else if (bus.tick) begin
                    by_s = by_r - 9'(SPEED);
                end else begin
                    state_s = FLY;
                end
            end
            COOL: begin
                if (cool_r == 8'd0) begin
                    state_s = IDLE;
                end else if (bus.tick) begin
                    cool_s = cool_r - 8'd1;
                end else begin
                    cool_s = cool_r;
                end
            end
            default: begin
                state_s = IDLE;
                bx_s    = 10'd0;
                by_s    = 9'd0;
                cool_s  = 8'd0;
            end
        endcase
    end

    // State, coordinate, counter and fire-edge registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            bx_r     <= 10'd0;
            by_r     <= 9'd0;
            shots_r  <= 8'd0;
            cool_r   <= 8'd0;
            active_r <= 1'b0;
            fire_q_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            bx_r     <= bx_s;
            by_r     <= by_s;
            shots_r  <= shots_s;
            cool_r   <= cool_s;
            active_r <= (state_s == FLY);
            fire_q_r <= bus.fire;
        end
    end

    // Widened so bx+BW / by+BH at the right and bottom edges cannot wrap.
    assign scan_x_s = {1'b0, bus.vga_x};
    assign scan_y_s = {2'b00, bus.vga_y};
    assign bx_w_s   = {1'b0, bx_r};
    assign by_w_s   = {2'b00, by_r};

    assign bus.pixel = active_r
                     && (bx_w_s <= scan_x_s) && (scan_x_s < bx_w_s + 11'(BW))
                     && (by_w_s <= scan_y_s) && (scan_y_s < by_w_s + 11'(BH));

    assign bus.bx     = bx_r;
    assign bus.by     = by_r;
    assign bus.active = active_r;
    assign bus.shots  = shots_r;

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: expectations queued with each stimulus step,
// popped and compared against the DUT after the clock that should produce them.
module tb_player_bullet;

    logic clk;
    logic reset;
    player_bullet_if bus();

    player_bullet dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fails++;
            $error("FAIL scoreboard_empty: observed %0d expected an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fails++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic exp_state(input string tag, input logic a, input logic [9:0] x,
                             input logic [8:0] y, input logic [7:0] s);
        push({tag, ".active"}, {31'd0, a});
        push({tag, ".bx"}, {22'd0, x});
        push({tag, ".by"}, {23'd0, y});
        push({tag, ".shots"}, {24'd0, s});
    endtask

    task automatic chk_state();
        pop_check({31'd0, bus.active});
        pop_check({22'd0, bus.bx});
        pop_check({23'd0, bus.by});
        pop_check({24'd0, bus.shots});
    endtask

    task automatic chk_pixel(input string tag, input logic [9:0] x, input logic [8:0] y,
                             input logic p);
        bus.vga_x = x;
        bus.vga_y = y;
        push(tag, {31'd0, p});
        #1;
        pop_check({31'd0, bus.pixel});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.tick  = 1'b0;
        bus.fire  = 1'b0;
        bus.px    = 10'd100;
        bus.gg    = 1'b0;
        bus.b_hit = 1'b0;
        bus.vga_x = 10'd0;
        bus.vga_y = 9'd0;
        step();
        step();
        exp_state("reset", 1'b0, 10'd0, 9'd0, 8'd0);
        chk_state();
        push("reset.pixel", 32'd0);
        pop_check({31'd0, bus.pixel});
        reset = 1'b0;
        step();

        // First shot: one clock latency from fire edge.
        bus.fire = 1'b1;
        exp_state("launch", 1'b1, 10'd103, 9'd170, 8'd1);
        step();
        chk_state();

        // Fire held high while flying must not re-launch.
        do_ticks(10);
        exp_state("fly10", 1'b1, 10'd103, 9'd140, 8'd1);
        chk_state();

        chk_pixel("pix_top_left", 10'd103, 9'd140, 1'b1);
        chk_pixel("pix_bottom", 10'd103, 9'd143, 1'b1);
        chk_pixel("pix_right_out", 10'd104, 9'd140, 1'b0);
        chk_pixel("pix_below_out", 10'd103, 9'd144, 1'b0);
        chk_pixel("pix_left_out", 10'd102, 9'd141, 1'b0);

        do_ticks(45);
        exp_state("fly_at5", 1'b1, 10'd103, 9'd5, 8'd1);
        chk_state();
        do_ticks(1);
        exp_state("fly_at2", 1'b1, 10'd103, 9'd2, 8'd1);
        chk_state();
        do_ticks(1);
        exp_state("miss_cool", 1'b0, 10'd0, 9'd0, 8'd1);
        chk_state();
        bus.fire = 1'b0;
        step();

        // Edge in cooldown (one tick still pending) is discarded.
        do_ticks(3);
        bus.fire = 1'b1;
        exp_state("cool_fire_ignored", 1'b0, 10'd0, 9'd0, 8'd1);
        step();
        chk_state();
        bus.fire = 1'b0;
        do_ticks(1);
        step();
        step();
        bus.fire = 1'b1;
        exp_state("relaunch", 1'b1, 10'd103, 9'd170, 8'd2);
        step();
        chk_state();
        bus.fire = 1'b0;

        // Hit has priority over tick in the same cycle.
        do_ticks(40);
        exp_state("fly_at50", 1'b1, 10'd103, 9'd50, 8'd2);
        chk_state();
        bus.b_hit = 1'b1;
        bus.tick  = 1'b1;
        exp_state("hit_cool", 1'b0, 10'd0, 9'd0, 8'd2);
        step();
        bus.b_hit = 1'b0;
        bus.tick  = 1'b0;
        chk_state();
        bus.fire = 1'b1;
        exp_state("hit_cool_fire", 1'b0, 10'd0, 9'd0, 8'd2);
        step();
        chk_state();
        bus.fire = 1'b0;
        do_ticks(4);
        step();
        step();

        // Game over cancels a flying shot and blocks new ones.
        bus.px   = 10'd200;
        bus.fire = 1'b1;
        exp_state("launch3", 1'b1, 10'd203, 9'd170, 8'd3);
        step();
        chk_state();
        bus.fire = 1'b0;
        bus.gg   = 1'b1;
        exp_state("gg_cancel", 1'b0, 10'd0, 9'd0, 8'd3);
        step();
        chk_state();
        do_ticks(4);
        step();
        step();
        bus.fire = 1'b1;
        exp_state("gg_block", 1'b0, 10'd0, 9'd0, 8'd3);
        step();
        chk_state();
        bus.fire = 1'b0;
        bus.gg   = 1'b0;
        step();

        // Saturating shot counter.
        for (int i = 0; i < 300; i++) begin
            bus.fire = 1'b1;
            step();
            bus.fire = 1'b0;
            bus.gg   = 1'b1;
            step();
            bus.gg   = 1'b0;
            if (i == 250) begin
                push("shots_254", 32'd254);
                pop_check({24'd0, bus.shots});
            end
            do_ticks(4);
            step();
            step();
        end
        push("shots_sat", 32'd255);
        pop_check({24'd0, bus.shots});

        // Asynchronous reset mid-flight.
        bus.px   = 10'd10;
        bus.fire = 1'b1;
        exp_state("launch_last", 1'b1, 10'd13, 9'd170, 8'd255);
        step();
        chk_state();
        bus.fire = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        exp_state("async_reset", 1'b0, 10'd0, 9'd0, 8'd0);
        chk_state();
        step();
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
